// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : clk_div_pkg
//  Description : Shared constants and helpers for the multi-channel clock
//                divider (board clock rate, common half-period divisors,
//                channel-select width and a target-frequency helper).
//  Revision    : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    localparam int CLK_HZ   = 100000000;
    localparam int DIV_1HZ  = 50000000;
    localparam int DIV_1KHZ = 50000;

    // Half-period in Clk cycles for an output of hz Hertz.
    function automatic int half_period(input int hz);
        return CLK_HZ / (2 * hz);
    endfunction

    // Width of a channel-select field; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_multi_if.sv
`default_nettype none
// ============================================================================
//  Interface   : clk_div_multi_if
//  Description : Run-control, configuration handshake and divided outputs of
//                clk_div_multi.
//                master : En, SyncRestart, CfgValid, CfgCh, CfgDiv out;
//                         CfgReady, ClkOut, Tick in.
//                slave  : the divider side of the same signals.
//  Revision    : 1.0  initial release
// ============================================================================
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26
);
    localparam int CH_W = clk_div_pkg::ch_w(NUM_CH);

    logic [NUM_CH-1:0] En;
    logic              SyncRestart;
    logic              CfgValid;
    logic              CfgReady;
    logic [CH_W-1:0]   CfgCh;
    logic [CNT_W-1:0]  CfgDiv;
    logic [NUM_CH-1:0] ClkOut;
    logic [NUM_CH-1:0] Tick;

    modport master (
        output En, SyncRestart, CfgValid, CfgCh, CfgDiv,
        input  CfgReady, ClkOut, Tick
    );

    modport slave (
        input  En, SyncRestart, CfgValid, CfgCh, CfgDiv,
        output CfgReady, ClkOut, Tick
    );

endinterface : clk_div_multi_if
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One divider channel. Counts 0..Div-1 and toggles its output
//                on the last count, giving a 2*Div period square wave and a
//                one-cycle tick on every rising edge.
//  Ports       : Clk, Rst (async, active-high)
//                i_en        run enable
//                i_restart   force phase 0
//                i_load      take i_load_div as the new divisor
//                o_clk       divided square wave (registered)
//                o_tick      one-cycle strobe on each o_clk rise
//                o_apply_ok  a pending divisor may be applied this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = DIV_1HZ
) (
    input  wire logic             Clk,
    input  wire logic             Rst,
    input  wire logic             i_en,
    input  wire logic             i_restart,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_div,
    output logic                  o_clk,
    output logic                  o_tick,
    output logic                  o_apply_ok
);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;

    logic w_active;
    logic w_last;

    // A zero divisor parks the channel just like a low enable.
    assign w_active = i_en && (r_div != '0);
    assign w_last   = w_active && (r_cnt == r_div - CNT_W'(1));

    // Updates land only on a half-period boundary while running, so the
    // output never sees a shortened half-period.
    assign o_apply_ok = !w_active || w_last;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_div  <= CNT_W'(DEF_DIV);
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            if (i_load) begin
                r_div <= i_load_div;
            end

            if (i_restart || !w_active) begin
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (w_last) begin
                // Counter restarts at 0, so a divisor loaded on this same
                // edge governs the following half-period.
                r_cnt  <= '0;
                r_clk  <= !r_clk;
                r_tick <= !r_clk;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_tick <= 1'b0;
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_multi
//  Description : NUM_CH independent programmable clock dividers sharing one
//                configuration slot. A divisor write is held pending until
//                the target channel can take it glitch-free.
//  Ports       : Clk, Rst (async, active-high)
//                bus  clk_div_multi_if.slave (En, SyncRestart, CfgValid,
//                     CfgReady, CfgCh, CfgDiv, ClkOut, Tick)
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = DIV_1HZ
) (
    input  wire logic           Clk,
    input  wire logic           Rst,
    clk_div_multi_if.slave      bus
);

    localparam int CH_W = ch_w(NUM_CH);

    logic             r_pend_v;
    logic [CH_W-1:0]  r_pend_ch;
    logic [CNT_W-1:0] r_pend_div;

    logic [NUM_CH-1:0] w_apply_ok;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_clk;
    logic [NUM_CH-1:0] w_tick;
    logic              w_xfer;
    logic              w_ch_ok;
    logic              w_apply;

    assign w_xfer  = bus.CfgValid && !r_pend_v;
    assign w_ch_ok = int'(bus.CfgCh) < NUM_CH;

    // A restart realigns every channel, so the pending value can land then.
    assign w_apply = r_pend_v && (bus.SyncRestart || w_apply_ok[r_pend_ch]);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_pend_v   <= 1'b0;
            r_pend_ch  <= '0;
            r_pend_div <= '0;
        end else if (w_apply) begin
            r_pend_v <= 1'b0;
        end else if (w_xfer && w_ch_ok) begin
            // Out-of-range channels are accepted but never occupy the slot.
            r_pend_v   <= 1'b1;
            r_pend_ch  <= bus.CfgCh;
            r_pend_div <= bus.CfgDiv;
        end
    end

    assign bus.CfgReady = !r_pend_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_load[i] = w_apply && (r_pend_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .Clk        (Clk),
            .Rst        (Rst),
            .i_en       (bus.En[i]),
            .i_restart  (bus.SyncRestart),
            .i_load     (w_load[i]),
            .i_load_div (r_pend_div),
            .o_clk      (w_clk[i]),
            .o_tick     (w_tick[i]),
            .o_apply_ok (w_apply_ok[i])
        );
    end

    assign bus.ClkOut = w_clk;
    assign bus.Tick   = w_tick;

endmodule : clk_div_multi
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_multi
//  Description : Self-checking bench for clk_div_multi. The reference model
//                describes each channel by an anchor time, a starting level
//                and a divisor; the output level follows from the elapsed
//                time divided by the divisor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clk_div_multi;

    localparam int NUM = 3;
    localparam int CW  = 8;
    localparam int CHW = 2;
    localparam int DEF = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clk_div_multi_if #(.NUM_CH(NUM), .CNT_W(CW)) bus ();

    clk_div_multi #(
        .NUM_CH  (NUM),
        .CNT_W   (CW),
        .DEF_DIV (DEF)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- reference model ----------------
    int m_now = 0;
    int m_start [NUM];
    int m_div   [NUM];
    bit m_base  [NUM];
    bit m_lvl   [NUM];
    bit m_tick  [NUM];
    bit m_pv;
    int m_pch;
    int m_pdiv;

    function automatic void m_reset();
        for (int c = 0; c < NUM; c++) begin
            m_start[c] = m_now;
            m_div[c]   = DEF;
            m_base[c]  = 1'b0;
            m_lvl[c]   = 1'b0;
            m_tick[c]  = 1'b0;
        end
        m_pv = 1'b0;
    endfunction

    function automatic bit m_level(input int c, input int t);
        if (m_div[c] == 0) return 1'b0;
        return m_base[c] ^ ((((t - m_start[c]) / m_div[c]) % 2) == 1);
    endfunction

    function automatic void m_edge();
        bit act, bnd, app, nv, any_app, sync;
        any_app = 1'b0;
        sync    = bus.SyncRestart;
        for (int c = 0; c < NUM; c++) begin
            act = bus.En[c] && (m_div[c] != 0);
            bnd = act && (((m_now - m_start[c]) % m_div[c]) == m_div[c] - 1);
            app = m_pv && (m_pch == c) && (sync || !act || bnd);
            if (sync || !act) begin
                nv = 1'b0;
                m_start[c] = m_now + 1;
                m_base[c]  = 1'b0;
            end else if (app) begin
                nv = !m_lvl[c];
                m_start[c] = m_now + 1;
                m_base[c]  = nv;
            end else begin
                nv = m_level(c, m_now + 1);
            end
            if (app) begin
                m_div[c] = m_pdiv;
                any_app  = 1'b1;
            end
            m_tick[c] = nv && !m_lvl[c];
            m_lvl[c]  = nv;
        end
        if (any_app) begin
            m_pv = 1'b0;
        end else if (bus.CfgValid && !m_pv && (int'(bus.CfgCh) < NUM)) begin
            m_pv   = 1'b1;
            m_pch  = int'(bus.CfgCh);
            m_pdiv = int'(bus.CfgDiv);
        end
        m_now++;
    endfunction

    function automatic logic [2*NUM:0] m_vec();
        logic [NUM-1:0] a, b;
        for (int c = 0; c < NUM; c++) begin
            a[c] = m_lvl[c];
            b[c] = m_tick[c];
        end
        return {a, b, !m_pv};
    endfunction

    // Advance one clock edge, update the model, settle 1 time unit past it.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            m_now++;
            m_reset();
        end else begin
            m_edge();
        end
        #1;
    endtask

    task automatic cfg_write(input int ch, input int dv);
        int k = 0;
        while (bus.CfgReady !== 1'b1 && k < 100) begin
            cyc();
            k++;
        end
        if (k >= 100) begin
            n_chk++;
            $display("FAIL cfg_ready_timeout: got CfgReady=%b expected 1", bus.CfgReady);
        end
        bus.CfgValid = 1'b1;
        bus.CfgCh    = CHW'(ch);
        bus.CfgDiv   = CW'(dv);
        cyc();
        bus.CfgValid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst             = 1'b0;
        bus.En          = '0;
        bus.SyncRestart = 1'b0;
        bus.CfgValid    = 1'b0;
        bus.CfgCh       = '0;
        bus.CfgDiv      = '0;
        #1 rst = 1'b1;
        #2;
        m_reset();
        n_chk++;
        if ({bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
            $display("FAIL reset_state: got %b expected %b", {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
        else n_pass++;
        cyc();
        rst = 1'b0;
        repeat (2) begin
            cyc();
            n_chk++;
            if ({bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
                $display("FAIL reset_idle t=%0d: got %b expected %b", m_now, {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
            else n_pass++;
        end
    endtask

    task automatic test_div3();
        int first = -1;
        cfg_write(0, 3);
        cyc();
        bus.En = 3'b001;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            n_chk++;
            if ({bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
                $display("FAIL div3 t=%0d: got %b expected %b", m_now, {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
            else n_pass++;
            if (first < 0 && bus.ClkOut[0] === 1'b1) first = k;
        end
        n_chk++;
        if (first !== 3) $display("FAIL div3_first_rise: got %0d expected 3", first);
        else n_pass++;
    endtask

    task automatic test_div1_park();
        cfg_write(1, 1);
        cfg_write(2, 0);
        bus.En = '1;
        repeat (12) begin
            cyc();
            n_chk++;
            if ({bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
                $display("FAIL div1_park t=%0d: got %b expected %b", m_now, {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
            else n_pass++;
        end
    endtask

    task automatic test_glitchfree();
        int run = 0, minrun = 99;
        bit started = 1'b0;
        logic prev;
        cfg_write(0, 5);
        repeat (16) begin
            cyc();
            n_chk++;
            if ({bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
                $display("FAIL glitch_pre t=%0d: got %b expected %b", m_now, {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
            else n_pass++;
        end
        cfg_write(0, 2);
        prev = bus.ClkOut[0];
        repeat (24) begin
            cyc();
            n_chk++;
            if ({bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
                $display("FAIL glitch_post t=%0d: got %b expected %b", m_now, {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
            else n_pass++;
            if (bus.ClkOut[0] !== prev) begin
                if (started && run < minrun) minrun = run;
                started = 1'b1;
                run = 1;
            end else begin
                run++;
            end
            prev = bus.ClkOut[0];
        end
        n_chk++;
        if (minrun !== 2) $display("FAIL glitch_min_half: got %0d expected 2", minrun);
        else n_pass++;
    endtask

    task automatic test_sync();
        int r0 = -1, r1 = -1;
        cfg_write(0, 4);
        cfg_write(1, 6);
        repeat (9) cyc();
        bus.SyncRestart = 1'b1;
        cyc();
        bus.SyncRestart = 1'b0;
        n_chk++;
        if ({bus.ClkOut, bus.Tick} !== '0)
            $display("FAIL sync_zero: got %b expected 0", {bus.ClkOut, bus.Tick});
        else n_pass++;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            n_chk++;
            if ({bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
                $display("FAIL sync_run t=%0d: got %b expected %b", m_now, {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
            else n_pass++;
            if (r0 < 0 && bus.ClkOut[0] === 1'b1) r0 = k;
            if (r1 < 0 && bus.ClkOut[1] === 1'b1) r1 = k;
        end
        n_chk++;
        if (r0 !== 4 || r1 !== 6)
            $display("FAIL sync_rise: got ch0=%0d ch1=%0d expected ch0=4 ch1=6", r0, r1);
        else n_pass++;
    endtask

    task automatic test_bad_ch();
        cfg_write(3, 1);
        n_chk++;
        if (bus.CfgReady !== 1'b1 || {bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
            $display("FAIL bad_ch: got %b expected %b", {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
        else n_pass++;
        bus.En[2] = 1'b0;
        cyc();
        n_chk++;
        if (bus.ClkOut[2] !== 1'b0 || {bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
            $display("FAIL en_off: got %b expected %b", {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(15) == 0) bus.En = NUM'($urandom);
            bus.SyncRestart = ($urandom_range(39) == 0);
            bus.CfgValid    = ($urandom_range(3) == 0);
            bus.CfgCh       = CHW'($urandom_range(3));
            bus.CfgDiv      = CW'($urandom_range(4));
            cyc();
            n_chk++;
            if ({bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
                $display("FAIL random t=%0d: got %b expected %b", m_now, {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
            else n_pass++;
        end
        bus.SyncRestart = 1'b0;
        bus.CfgValid    = 1'b0;
    endtask

    task automatic test_async_rst();
        int first = -1;
        bus.En = '1;
        cfg_write(0, 4);
        cfg_write(0, 7);
        #2 rst = 1'b1;
        #1;
        m_reset();
        n_chk++;
        if ({bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
            $display("FAIL async_rst: got %b expected %b", {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
        else n_pass++;
        cyc();
        rst = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            cyc();
            n_chk++;
            if ({bus.ClkOut, bus.Tick, bus.CfgReady} !== m_vec())
                $display("FAIL post_rst t=%0d: got %b expected %b", m_now, {bus.ClkOut, bus.Tick, bus.CfgReady}, m_vec());
            else n_pass++;
            if (first < 0 && bus.ClkOut[0] === 1'b1) first = k;
        end
        n_chk++;
        if (first !== DEF) $display("FAIL post_rst_rise: got %0d expected %0d", first, DEF);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_div3();
        test_div1_park();
        test_glitchfree();
        test_sync();
        test_bad_ch();
        test_random();
        test_async_rst();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_clk_div_multi
`default_nettype wire
